// File: rtl/block_mem_arbiter_pkg.sv
// Shared definitions for the block-memory arbiter: default geometry and FSM encoding.
`timescale 1ns/1ps
package block_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/block_mem_arbiter_if.sv
// Requester-side req/ack handshake bundle for one memory port.
`timescale 1ns/1ps
interface block_mem_arbiter_if
  import block_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, output we, output addr, output wdata, input ack, input rdata);
  modport slave  (input req, input we, input addr, input wdata, output ack, output rdata);

endinterface

// File: rtl/block_mem_arbiter_rr.sv
// Two-way round-robin grant selection; remembers the last winner so ties alternate.
`timescale 1ns/1ps
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_stb,
  output logic       grant
);

  logic last_grant_r;

  // Grant index: lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_r;
      default: grant = 1'b0;
    endcase
  end

  // Starts at 1 so port 0 takes the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (grant_stb) begin
      last_grant_r <= grant;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/block_mem_arbiter.sv
// Serializes two req/ack ports onto one single-port block memory, hiding its read latency.
`timescale 1ns/1ps
module block_mem_arbiter
  import block_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  block_mem_arbiter_if.slave p0,
  block_mem_arbiter_if.slave p1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_e        state_r;
  logic              grant_r;
  logic              we_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        req_s;
  logic              grant_s;
  logic              grant_stb_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  assign req_s       = {p1.req, p0.req};
  assign grant_stb_s = (state_r == ST_IDLE) && (|req_s);

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_s),
    .grant_stb (grant_stb_s),
    .grant     (grant_s)
  );

  // Route the winning requester's command toward the latches.
  always_comb begin
    sel_we_s    = p0.we;
    sel_addr_s  = p0.addr;
    sel_wdata_s = p0.wdata;
    if (grant_s) begin
      sel_we_s    = p1.we;
      sel_addr_s  = p1.addr;
      sel_wdata_s = p1.wdata;
    end else begin
      sel_we_s    = p0.we;
      sel_addr_s  = p0.addr;
      sel_wdata_s = p0.wdata;
    end
  end

  // Sequencer: mem_addr/mem_din double as the command latch, so they only move on a new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      grant_r  <= 1'b0;
      we_r     <= 1'b0;
      cnt_r    <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      p0.ack   <= 1'b0;
      p1.ack   <= 1'b0;
      p0.rdata <= '0;
      p1.rdata <= '0;
    end else begin
      mem_we <= 1'b0;
      p0.ack <= 1'b0;
      p1.ack <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|req_s) begin
            grant_r  <= grant_s;
            we_r     <= sel_we_s;
            mem_we   <= sel_we_s;
            mem_addr <= sel_addr_s;
            mem_din  <= sel_wdata_s;
            state_r  <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (we_r) begin
            if (grant_r) p1.ack <= 1'b1;
            else         p0.ack <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= CNT_W'(RD_LAT - 1);
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r == '0) begin
            if (grant_r) begin
              p1.rdata <= mem_dout;
              p1.ack   <= 1'b1;
            end else begin
              p0.rdata <= mem_dout;
              p0.ack   <= 1'b1;
            end
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_mem_arbiter.sv
// Directed self-checking bench for block_mem_arbiter with a registered-read memory model behind it.
`timescale 1ns/1ps
module tb_block_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic [15:0] mem_array [0:1023];

  int checks;
  int errors;

  block_mem_arbiter_if p0_if ();
  block_mem_arbiter_if p1_if ();

  block_mem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0       (p0_if.slave),
    .p1       (p1_if.slave),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port block memory, read-first, one-clock registered read, zero-initialised.
  initial begin
    for (int i = 0; i < 1024; i++) mem_array[i] = 16'h0000;
    mem_dout = 16'h0000;
  end
  always @(posedge clk) begin
    if (mem_we) mem_array[mem_addr] <= mem_din;
    mem_dout <= mem_array[mem_addr];
  end

  initial begin
    #200us;
    $display("FAIL watchdog: time %0t exceeded, required completion", $time);
    $fatal(1, "watchdog");
  end

  // One transaction on one port; reports ack latency (cycles from the req-raise negedge) and mem activity.
  task automatic do_access(input int port, input logic we, input logic [9:0] addr, input logic [15:0] wdata,
                           output int ack_cyc, output int we_cnt, output logic [9:0] we_addr,
                           output logic [15:0] we_din, output logic [15:0] rd);
    ack_cyc = -1; we_cnt = 0; we_addr = 10'h000; we_din = 16'h0000; rd = 16'h0000;
    @(negedge clk);
    if (port == 0) begin
      p0_if.req = 1'b1; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
    end else begin
      p1_if.req = 1'b1; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
    end
    for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_addr = mem_addr; we_din = mem_din; end
      if (port == 0 && p0_if.ack) begin ack_cyc = c; rd = p0_if.rdata; p0_if.req = 1'b0; end
      else if (port == 1 && p1_if.ack) begin ack_cyc = c; rd = p1_if.rdata; p1_if.req = 1'b0; end
    end
    p0_if.req = 1'b0;
    p1_if.req = 1'b0;
  endtask

  task automatic test_reset();
    int we_hi;
    rst_n = 1'b0;
    #50;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
    checks++; if ({p0_if.ack, p1_if.ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b want 00", {p0_if.ack, p1_if.ack}); end
    checks++; if (p0_if.rdata !== 16'h0000 || p1_if.rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h/%h want 0000/0000", p0_if.rdata, p1_if.rdata); end
    checks++; if (mem_addr !== 10'h000 || mem_din !== 16'h0000) begin errors++; $display("FAIL reset_mem_bus got %h/%h want 000/0000", mem_addr, mem_din); end
    #50;
    @(negedge clk);
    rst_n = 1'b1;
    we_hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_we) we_hi++;
    end
    checks++; if (we_hi !== 0) begin errors++; $display("FAIL idle_mem_we got %0d high cycles want 0", we_hi); end
  endtask

  task automatic test_write_read();
    int ack_cyc, we_cnt;
    logic [9:0] wa; logic [15:0] wd, rd;
    do_access(0, 1'b1, 10'h26f, 16'h1111, ack_cyc, we_cnt, wa, wd, rd);
    checks++; if (ack_cyc !== 2) begin errors++; $display("FAIL wr_latency got %0d want 2", ack_cyc); end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL wr_we_pulses got %0d want 1", we_cnt); end
    checks++; if (wa !== 10'h26f || wd !== 16'h1111) begin errors++; $display("FAIL wr_bus got %h/%h want 26f/1111", wa, wd); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL wr_keeps_rdata got %h want 0000", rd); end
    @(negedge clk);
    checks++; if (p0_if.ack !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got %0b want 0", p0_if.ack); end
    do_access(0, 1'b0, 10'h26f, 16'h0000, ack_cyc, we_cnt, wa, wd, rd);
    checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", ack_cyc); end
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL rd_data got %h want 1111", rd); end
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL rd_no_we got %0d want 0", we_cnt); end
  endtask

  task automatic test_first_tie();
    int a0, a1;
    rst_n = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a0 = -1; a1 = -1;
    p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 10'h2dd; p0_if.wdata = 16'h2222;
    p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 10'h2dd; p1_if.wdata = 16'h0000;
    for (int c = 1; c <= 20 && (a0 < 0 || a1 < 0); c++) begin
      @(negedge clk);
      if (p0_if.ack) begin a0 = c; p0_if.req = 1'b0; end
      if (p1_if.ack) begin a1 = c; p1_if.req = 1'b0; end
    end
    p0_if.req = 1'b0; p1_if.req = 1'b0;
    checks++; if (a0 !== 2) begin errors++; $display("FAIL tie_p0_first got ack at %0d want 2", a0); end
    checks++; if (a1 !== 6) begin errors++; $display("FAIL tie_p1_second got ack at %0d want 6", a1); end
    checks++; if (p1_if.rdata !== 16'h2222) begin errors++; $display("FAIL tie_p1_rdata got %h want 2222", p1_if.rdata); end
  endtask

  task automatic test_back_to_back();
    int order [0:7];
    int n, n0, n1, last0, last1;
    @(negedge clk);
    n = 0; n0 = 0; n1 = 0; last0 = -1; last1 = -1;
    p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 10'h14c; p0_if.wdata = 16'h4000;
    p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 10'h14c; p1_if.wdata = 16'h0000;
    for (int c = 1; c <= 60 && n < 8; c++) begin
      @(negedge clk);
      if (p0_if.ack) begin
        order[n] = 0; n++;
        if (last0 >= 0) begin
          checks++; if (c - last0 !== 7) begin errors++; $display("FAIL b2b_p0_spacing got %0d want 7", c - last0); end
        end
        last0 = c; n0++;
        p0_if.addr = 10'h14c + 10'(n0); p0_if.wdata = 16'h4000 + 16'(n0);
        if (n0 == 4) p0_if.req = 1'b0;
      end
      if (p1_if.ack) begin
        order[n] = 1; n++;
        checks++; if (p1_if.rdata !== 16'h4000 + 16'(n1)) begin errors++; $display("FAIL b2b_p1_rdata got %h want %h", p1_if.rdata, 16'h4000 + 16'(n1)); end
        if (last1 >= 0) begin
          checks++; if (c - last1 !== 7) begin errors++; $display("FAIL b2b_p1_spacing got %0d want 7", c - last1); end
        end
        last1 = c; n1++;
        p1_if.addr = 10'h14c + 10'(n1);
        if (n1 == 4) p1_if.req = 1'b0;
      end
    end
    p0_if.req = 1'b0; p1_if.req = 1'b0;
    checks++; if (n !== 8) begin errors++; $display("FAIL b2b_count got %0d want 8", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (order[i] !== (i % 2)) begin errors++; $display("FAIL b2b_order idx %0d got p%0d want p%0d", i, order[i], i % 2); end
    end
  endtask

  task automatic test_reset_mid_access();
    int acks, ack_cyc, we_cnt;
    logic [9:0] wa; logic [15:0] wd, rd;
    @(negedge clk);
    p1_if.req = 1'b1; p1_if.we = 1'b1; p1_if.addr = 10'h24c; p1_if.wdata = 16'h3333;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'h24c) begin errors++; $display("FAIL mid_access_setup got we=%0b addr=%h want 1/24c", mem_we, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_reset_we_drop got %0b want 0", mem_we); end
    p1_if.req = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (p0_if.ack || p1_if.ack) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL mid_reset_no_ack got %0d acks want 0", acks); end
    do_access(0, 1'b1, 10'h24c, 16'h5555, ack_cyc, we_cnt, wa, wd, rd);
    checks++; if (ack_cyc !== 2 || wa !== 10'h24c) begin errors++; $display("FAIL post_reset_p0_wr got ack %0d addr %h want 2/24c", ack_cyc, wa); end
    do_access(1, 1'b0, 10'h24c, 16'h0000, ack_cyc, we_cnt, wa, wd, rd);
    checks++; if (ack_cyc !== 3 || rd !== 16'h5555) begin errors++; $display("FAIL post_reset_p1_rd got ack %0d data %h want 3/5555", ack_cyc, rd); end
  endtask

  task automatic test_boundaries();
    int ack_cyc, we_cnt;
    logic [9:0] wa; logic [15:0] wd, rd;
    do_access(0, 1'b1, 10'h000, 16'hffff, ack_cyc, we_cnt, wa, wd, rd);
    checks++; if (ack_cyc !== 2 || wa !== 10'h000 || wd !== 16'hffff) begin errors++; $display("FAIL bnd_wr_low got ack %0d %h/%h want 2 000/ffff", ack_cyc, wa, wd); end
    do_access(1, 1'b1, 10'h3ff, 16'h0001, ack_cyc, we_cnt, wa, wd, rd);
    checks++; if (ack_cyc !== 2 || wa !== 10'h3ff || wd !== 16'h0001) begin errors++; $display("FAIL bnd_wr_high got ack %0d %h/%h want 2 3ff/0001", ack_cyc, wa, wd); end
    checks++; if (p1_if.rdata !== 16'h5555) begin errors++; $display("FAIL bnd_wr_keeps_rdata got %h want 5555", p1_if.rdata); end
    do_access(0, 1'b0, 10'h3ff, 16'h0000, ack_cyc, we_cnt, wa, wd, rd);
    checks++; if (ack_cyc !== 3 || rd !== 16'h0001) begin errors++; $display("FAIL bnd_rd_high got ack %0d data %h want 3/0001", ack_cyc, rd); end
    checks++; if (p1_if.rdata !== 16'h5555) begin errors++; $display("FAIL bnd_other_rdata got %h want 5555", p1_if.rdata); end
    do_access(1, 1'b0, 10'h000, 16'h0000, ack_cyc, we_cnt, wa, wd, rd);
    checks++; if (ack_cyc !== 3 || rd !== 16'hffff) begin errors++; $display("FAIL bnd_rd_low got ack %0d data %h want 3/ffff", ack_cyc, rd); end
    do_access(0, 1'b0, 10'h1cf, 16'h0000, ack_cyc, we_cnt, wa, wd, rd);
    checks++; if (ack_cyc !== 3 || rd !== 16'h0000) begin errors++; $display("FAIL bnd_rd_unwritten got ack %0d data %h want 3/0000", ack_cyc, rd); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = 10'h000; p0_if.wdata = 16'h0000;
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = 10'h000; p1_if.wdata = 16'h0000;
    test_reset();
    test_write_read();
    test_first_tie();
    test_back_to_back();
    test_reset_mid_access();
    test_boundaries();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
